// File: rtl/instruction_memory_loader_if.sv
// ============================================================================
// Module   : instruction_memory_loader_if
// Summary  : Stream, memory-write and status bundle for instruction_memory_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instruction_memory_loader_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  i_start;
   logic [DATA_WIDTH-1:0] i_in_data;
   logic                  i_in_valid;
   logic                  o_in_ready;
   logic                  o_mem_write_enable;
   logic [ADDR_WIDTH-1:0] o_mem_address;
   logic [DATA_WIDTH-1:0] o_mem_write_data;
   logic                  o_busy;
   logic                  o_cpu_hold;
   logic                  o_done;
   logic                  o_error;

   // Loader side
   modport slave (
      input  i_start, i_in_data, i_in_valid,
      output o_in_ready, o_mem_write_enable, o_mem_address, o_mem_write_data,
      output o_busy, o_cpu_hold, o_done, o_error
   );

   // Host side
   modport master (
      output i_start, i_in_data, i_in_valid,
      input  o_in_ready, o_mem_write_enable, o_mem_address, o_mem_write_data,
      input  o_busy, o_cpu_hold, o_done, o_error
   );
endinterface

`default_nettype wire

// File: rtl/instruction_memory_loader.sv
// ============================================================================
// Module   : instruction_memory_loader
// Summary  : Writes a framed word stream (addr hi, addr lo, count, payload)
//            into instruction memory while holding the CPU. Optional trailing
//            XOR checksum word when LOADER_CHECKSUM_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_memory_loader #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned MEM_DEPTH_LOG2 = 21
) (
   input  wire logic                   i_clk,
   input  wire logic                   i_reset,
   instruction_memory_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADDR_HI = 3'd1,
      S_ADDR_LO = 3'd2,
      S_COUNT   = 3'd3,
      S_DATA    = 3'd4,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK   = 3'd5,
`endif
      S_DONE    = 3'd6
   } state_t;

   // State entered once the payload is exhausted
`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHECK;
`else
   localparam state_t S_TAIL = S_DONE;
`endif

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic                  error_q, error_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

   logic w_xfer;
   logic w_in_range;

   assign w_xfer = bus.i_in_valid && ready_q;

   generate
      if (MEM_DEPTH_LOG2 >= ADDR_WIDTH) begin : g_range_full
         assign w_in_range = 1'b1;
      end else begin : g_range_cmp
         assign w_in_range = (addr_q[ADDR_WIDTH-1:MEM_DEPTH_LOG2] == '0);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      error_d = error_q;
      we_d    = 1'b0;
      maddr_d = maddr_q;
      mdata_d = mdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               state_d = S_ADDR_HI;
               error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_ADDR_HI: begin
            if (w_xfer) begin
               addr_d  = ADDR_WIDTH'({bus.i_in_data, {DATA_WIDTH{1'b0}}});
               state_d = S_ADDR_LO;
            end
         end
         S_ADDR_LO: begin
            if (w_xfer) begin
               addr_d  = addr_q | ADDR_WIDTH'(bus.i_in_data);
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (w_xfer) begin
               count_d = bus.i_in_data;
               state_d = (bus.i_in_data == '0) ? S_TAIL : S_DATA;
            end
         end
         S_DATA: begin
            if (w_xfer) begin
               // Out-of-range words are still consumed to keep the stream framed
               if (w_in_range) begin
                  we_d    = 1'b1;
                  maddr_d = addr_q;
                  mdata_d = bus.i_in_data;
               end else begin
                  error_d = 1'b1;
               end
               addr_d  = addr_q + ADDR_WIDTH'(1);
               count_d = count_q - DATA_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ bus.i_in_data;
`endif
               if (count_q == DATA_WIDTH'(1)) begin
                  state_d = S_TAIL;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (w_xfer) begin
               if (csum_q != bus.i_in_data) begin
                  error_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d != S_IDLE) && (state_d != S_DONE);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         error_q <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         maddr_q <= '0;
         mdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         error_q <= error_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         mdata_q <= mdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign bus.o_in_ready         = ready_q;
   assign bus.o_mem_write_enable = we_q;
   assign bus.o_mem_address      = maddr_q;
   assign bus.o_mem_write_data   = mdata_q;
   assign bus.o_busy             = busy_q;
   assign bus.o_cpu_hold         = busy_q;
   assign bus.o_done             = done_q;
   assign bus.o_error            = error_q;

endmodule

`default_nettype wire
